// File: rtl/seq_mult16_pkg.sv
// Shared definitions for the sequential shift-add multiplier: the default
// operand width and the controller state encoding.
package seq_mult16_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEFAULT_WIDTH = 16;

    // Controller states. The encoding is fixed so that debug taps and
    // external observers see stable values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_mult16_pkg

// File: rtl/seq_mult16_abs16.sv
// Combinational two's-complement magnitude. The magnitude is returned as an
// unsigned WIDTH-bit value, so the most negative input maps to itself
// (for example 0x8000 -> 0x8000), which is the correct unsigned magnitude.
module abs16 #(
    parameter int WIDTH = seq_mult16_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             sign_o
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    // Select the raw value or its negation depending on the sign bit.
    always_comb begin
        sign_o = val_i[WIDTH-1];
        if (val_i[WIDTH-1]) begin
            mag_o = (~val_i) + ONE_W;
        end else begin
            mag_o = val_i;
        end
    end

endmodule : abs16

// File: rtl/seq_mult16.sv
// Multi-cycle WIDTH x WIDTH shift-add multiplier with a start/ready handshake.
// Signed operation is handled by multiplying magnitudes and negating the
// result at the end, so the datapath itself is purely unsigned.
module seq_mult16
    import seq_mult16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_en,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Counter must be able to hold WIDTH itself.
    localparam int                 CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH);
    localparam logic [2*WIDTH-1:0] PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Architectural state
    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH:0]     acc_q,     acc_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic                 neg_q,     neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ready_q,   ready_d;
    logic                 done_q,    done_d;

    // Datapath helpers
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH:0]     shifted_s;
    logic [2*WIDTH-1:0]   acc_fin_s;
    logic [2*WIDTH-1:0]   result_s;

    abs16 #(.WIDTH(WIDTH)) u_abs_a (
        .val_i  (op_a),
        .mag_o  (mag_a_s),
        .sign_o (sign_a_s)
    );

    abs16 #(.WIDTH(WIDTH)) u_abs_b (
        .val_i  (op_b),
        .mag_o  (mag_b_s),
        .sign_o (sign_b_s)
    );

    // One shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB is set, keeping the carry in the extra top bit, then
    // shift the whole accumulator right by one.
    always_comb begin
        if (mplier_q[0]) begin
            addend_s = mcand_q;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s     = acc_q[2*WIDTH:WIDTH] + {1'b0, addend_s};
        shifted_s = {1'b0, sum_s, acc_q[WIDTH-1:1]};
    end

    // Final sign fix-up applied to the last accumulator value, modulo 2^(2W).
    always_comb begin
        acc_fin_s = shifted_s[2*WIDTH-1:0];
        if (neg_q) begin
            result_s = (~acc_fin_s) + PROD_ONE;
        end else begin
            result_s = acc_fin_s;
        end
    end

    // Controller next-state and datapath update; everything holds by default.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_ZERO;
                    acc_d   = {(2*WIDTH+1){1'b0}};
                    if (signed_en) begin
                        mcand_d  = mag_a_s;
                        mplier_d = mag_b_s;
                        neg_d    = sign_a_s ^ sign_b_s;
                    end else begin
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        neg_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                acc_d    = shifted_s;
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_d == CNT_LAST) begin
                    state_d   = ST_DONE;
                    product_d = result_s;
                end else begin
                    state_d = ST_BUSY;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // exactly with the state register.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            acc_q     <= {(2*WIDTH+1){1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            neg_q     <= 1'b0;
            product_q <= {(2*WIDTH){1'b0}};
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : seq_mult16

// File: doc/seq_mult16.md
# seq_mult16

Multi-cycle 16×16 shift-add multiplier sitting directly downstream of the 16-bit 4:1 operand mux. Operand A is the mux output Y; operand B comes from the register bank. It accepts one operation per start/ready handshake and produces a 32-bit product after a fixed iteration count. The product is held until the next operation completes, so the writeback path can sample it at leisure.

## Interface
- `WIDTH`, default 16: operand width. Product is 2·WIDTH bits; iteration count equals WIDTH.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous to `clk`, active-low. One clock; reset is synchronous and active-low.
- `start`  in  1  request; accepted only when `ready`=1.
- `signed_en`  in  1  1 = two's-complement operands; 0 = unsigned. Captured with `start`.
- `op_a`  in  WIDTH  multiplicand, from mux Y.
- `op_b`  in  WIDTH  multiplier.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse when `product` is updated.
- `product`  out  2·WIDTH  registered result, held between operations.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE→BUSY on `start`=1.
  - BUSY→DONE when the iteration counter reaches WIDTH.
  - DONE→IDLE unconditionally.
- Capture at accept:
  - `signed_en`=1: store |op_a|, |op_b| as WIDTH-bit unsigned magnitudes and neg = a[MSB]^b[MSB]. |0x8000| = 0x8000 is representable as unsigned.
  - `signed_en`=0: store raw operands and neg=0.
  - Clear the accumulator and the counter.
- Each BUSY cycle:
  - If multiplier LSB=1, add the multiplicand into the upper half of the 2·WIDTH+1-bit accumulator.
  - Shift the accumulator right by 1; shift the multiplier right by 1.
  - Increment the counter.
  - No carry may be lost.
- On the final iteration, write `product` as the accumulator, or its two's-complement negation if neg=1. The negation is modulo 2^(2·WIDTH).
- Fixed latency regardless of operand values; zero operands still take WIDTH cycles.
- `start` is ignored in BUSY and DONE. Operand and `signed_en` changes after accept have no effect.
- `product` changes only on the final iteration edge and on reset.

## Timing
- Accept at rising edge N (`start`=1, `ready`=1). `ready` drops after edge N.
- Iterations occur at edges N+1 … N+WIDTH (N+16 for the default). `product` is written at edge N+WIDTH.
- `done`=1 and state=DONE between edges N+WIDTH and N+WIDTH+1. `ready`=1 again after edge N+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles.
- `start` held continuously: next accept at edge N+WIDTH+2.
- Reset values (after a clock edge with `rst_n`=0): state IDLE, `ready`=1, `done`=0, `product`=0, counter/accumulator/neg=0.
- Reset mid-BUSY or in DONE: the operation is abandoned, with no `done` pulse. Reset has priority over `start` at the same edge.

## Structure
- Shared package:
  - state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - the default WIDTH constant.
- The counter width is clog2(WIDTH)+1, derived locally.
- One sub-module: `abs16`, combinational WIDTH-bit magnitude with sign output. It is instantiated twice, once per operand.
- The final conditional negate is inline.

## Test plan
- Unsigned 3×5, `start` at edge N:
  - `done` high exactly in cycle N+16 to N+17;
  - `product`=0x0000000F;
  - `ready`=0 from N+1 through N+17.
- Unsigned 0xFFFF×0xFFFF → 0xFFFE0001. Also 0x0000×0x1234 → 0x00000000 with the same 16-cycle latency.
- Signed 0xFFFD×0x0007 (−3×7) → 0xFFFFFFEB. Signed 0xFFFF×0xFFFF → 0x00000001.
- Signed boundary cases:
  - 0x8000×0x8000 → 0x40000000;
  - 0x8000×0x0001 → 0xFFFF8000;
  - the same 0x8000×0x0001 unsigned → 0x00008000.
- Accept 0x0002×0x0003, then pulse `start` with 0x00FF×0x00FF at iteration 5:
  - result is 0x00000006;
  - only one `done` pulse.
- Reset and hold behaviour:
  - `rst_n` low for one edge at iteration 8 → next cycle `ready`=1, `done`=0, `product`=0;
  - a new 4×4 then yields 0x00000010;
  - the prior `product` is held across idle cycles.
